// File: rtl/sipo_frame_pkg.sv
// Shared state encoding and line levels for the SIPO framing controller.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sipo_word_buf.sv
// One-entry valid/ready holding register; flags a word offered while full and unread.
module sipo_word_buf #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  // A read on the same edge frees the slot, so the new word is accepted.
  logic slot_free;
  assign slot_free = !data_valid || data_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && !slot_free;
      if (load && slot_free) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start/stop framing FSM and shift register feeding a one-word output buffer.
// Optional even-parity check before the stop bit when PARITY_CHECK_EN is defined.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              serial_in,
  output logic              shift_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
`ifdef PARITY_CHECK_EN
  output logic              parity_err,
`endif
  output logic              frame_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt, cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              load;
  logic              ferr_d;
`ifdef PARITY_CHECK_EN
  logic              perr_d;
`endif

  assign shift_en = sample_en && (state_q == DATA);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_cnt;
    shreg_d = shreg;
    load    = 1'b0;
    ferr_d  = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_LVL) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {shreg[DATA_W-2:0], serial_in};
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = bit_cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (serial_in == ^shreg) begin
            state_d = STOP;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end
`endif
        STOP: begin
          // A low stop bit is consumed here; start detection resumes on the next strobe.
          if (serial_in == STOP_LVL) load = 1'b1;
          else                       ferr_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt   <= cnt_d;
      shreg     <= shreg_d;
      frame_err <= ferr_d;
`ifdef PARITY_CHECK_EN
      parity_err <= perr_d;
`endif
    end
  end

  sipo_word_buf #(.DATA_W(DATA_W)) u_word_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .word       (shreg),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: frame table plus handshake, gating and reset sequences.
module tb_sipo_frame_ctrl;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en;
  logic              serial_in;
  logic              data_ready;
  logic              shift_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              overrun;
`ifdef PARITY_CHECK_EN
  logic              parity_err;
`endif

  sipo_frame_ctrl #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .serial_in  (serial_in),
    .shift_en   (shift_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
`ifdef PARITY_CHECK_EN
    .parity_err (parity_err),
`endif
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic              stop;
    logic              exp_valid;
    logic              exp_ferr;
  } vec_t;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] sb_q[$];
  int                shift_cnt = 0;
  int                ovr_seen = 0;
  int                ferr_seen = 0;
  logic              ferr_prev = 1'b0;
  logic              ovr_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Observe outputs on the falling edge; a word is consumed when valid&ready is seen there.
  task automatic monitor();
    logic [DATA_W-1:0] exp_word;
    if (rst_n) begin
      if (shift_en) shift_cnt++;
      if (data_valid && data_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          exp_word = sb_q.pop_front();
          check("sb_word", 32'(data_out), 32'(exp_word));
        end
      end
      if (frame_err || overrun) check("flag_excl", 32'(frame_err && overrun), 0);
      if (frame_err) begin
        check("ferr_width", 32'(ferr_prev), 0);
        ferr_seen++;
      end
      if (overrun) begin
        check("ovr_width", 32'(ovr_prev), 0);
        ovr_seen++;
      end
    end
    ferr_prev = frame_err;
    ovr_prev  = overrun;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic gap);
    if (gap) begin
      sample_en = 1'b0;
      serial_in = ~serial_in;
      tick();
    end
    sample_en = 1'b1;
    serial_in = b;
    tick();
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop,
                            input logic gap, input logic rdy_stop);
    int s0;
    s0 = shift_cnt;
    send_bit(1'b0, gap);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(word[i], gap);
    data_ready = rdy_stop;
    send_bit(stop, gap);
    check("shift_en_count", shift_cnt - s0, DATA_W);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    for (int i = 0; i < 20 && (sb_q.size() != 0 || data_valid); i++) tick();
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   o0;
    vecs[0] = '{4'b1011, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{4'b0110, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0011, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'b1000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{4'b1111, 1'b1, 1'b1, 1'b0};

    rst_n      = 1'b0;
    sample_en  = 1'b1;
    serial_in  = 1'b1;
    data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_shift_en", 32'(shift_en), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_high_shift_en", 32'(shift_en), 0);

    // Back-to-back frames with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      data_ready = 1'b1;
      if (vecs[i].exp_valid) sb_q.push_back(vecs[i].word);
      send_frame(vecs[i].word, vecs[i].stop, 1'b0, 1'b1);
      check($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("tbl%0d_ovr", i), 32'(overrun), 0);
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), 32'(data_out), 32'(vecs[i].word));
    end
    drain();
    check("ferr_pulses", ferr_seen, 2);

    // Backpressure: second word dropped with a single overrun pulse.
    data_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    check("bp_valid", 32'(data_valid), 1);
    check("bp_data", 32'(data_out), 32'(4'b1011));
    o0 = ovr_seen;
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
    check("bp_ovr", 32'(overrun), 1);
    check("bp_hold_data", 32'(data_out), 32'(4'b1011));
    check("bp_hold_valid", 32'(data_valid), 1);
    tick();
    check("bp_ovr_clear", 32'(overrun), 0);
    check("bp_ovr_count", ovr_seen - o0, 1);
    data_ready = 1'b1;
    tick();
    check("bp_read_clears", 32'(data_valid), 0);
    drain();

    // Read and load on the same edge: no overrun, new word replaces old.
    data_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    o0 = ovr_seen;
    sb_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b1);
    check("sim_ovr", 32'(overrun), 0);
    check("sim_valid", 32'(data_valid), 1);
    check("sim_data", 32'(data_out), 32'(4'b0110));
    tick();
    check("sim_ovr_count", ovr_seen - o0, 0);
    check("sim_cleared", 32'(data_valid), 0);
    drain();

    // Strobe gating: sample_en every other cycle decodes identically.
    data_ready = 1'b1;
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1);
    check("gate_valid", 32'(data_valid), 1);
    check("gate_data", 32'(data_out), 32'(4'b1011));
    drain();

    // Asynchronous reset mid-frame while a word is held.
    data_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("pre_rst_shift_en", 32'(shift_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(data_valid), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_shift_en", 32'(shift_en), 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    data_ready = 1'b1;
    sb_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b1);
    check("post_rst_valid", 32'(data_valid), 1);
    check("post_rst_data", 32'(data_out), 32'(4'b0110));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
